interrupt_controller: RTL and testbench

Receiving end of the peripheral interrupt lines: the timer, LCD, serial and joypad blocks raise single-cycle request pulses here. The block owns IF (0xFF0F), IE (0xFFFF) and IME, arbitrates by fixed priority at instruction boundaries, and runs a request/acknowledge handshake with the CPU core to dispatch the vector. It also drives a HALT wake line.

---
 rtl/interrupt_controller_pkg.sv | 26 ++
 rtl/interrupt_priority_encoder.sv | 30 +++
 rtl/interrupt_controller.sv | 147 ++++++++++++++
 tb/tb_interrupt_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: IRQ map,
// vector base, CPU opcodes and dispatch FSM states.
package interrupt_controller_pkg;

  localparam int unsigned INT_NUM_IRQ = 5;
  localparam logic [7:0] INT_VECTOR_BASE = 8'h40;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_LCD_STAT = 1;
  localparam int unsigned IRQ_TIMER = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam logic [7:0] Z80_EI = 8'hFB;
  localparam logic [7:0] Z80_DI = 8'hF3;
  localparam logic [7:0] Z80_RETI = 8'hD9;

  localparam logic [3:0] IF_SELECT = 4'hF;

  typedef enum logic [1:0] {
    INT_IDLE = 2'd0,
    INT_REQ = 2'd1,
    INT_ACK = 2'd2
  } int_state_e;

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority pick over pending interrupts: the lowest
// set bit wins and maps to VECTOR_BASE + 8*index.
module interrupt_priority_encoder
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = INT_NUM_IRQ,
  parameter logic [7:0] VECTOR_BASE = INT_VECTOR_BASE,
  parameter int unsigned IDX_W = $clog2(INT_NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] pend_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o,
  output logic [7:0]         vec_o
);

  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    vec_o = VECTOR_BASE;
    // Walk downward so the lowest set bit is written last.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_i[i]) begin
        idx_o = IDX_W'(i);
        valid_o = 1'b1;
        vec_o = VECTOR_BASE + 8'(8 * i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE/IME ownership, boundary-qualified arbitration and
// request/ack vector dispatch toward the CPU core.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_IRQ = INT_NUM_IRQ,
  parameter logic [7:0] VECTOR_BASE = INT_VECTOR_BASE
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [NUM_IRQ-1:0] iInterruptRequest,
  input  logic [7:0]         iOpcode,
  input  logic               iEof,
  input  logic               iMcuWe,
  input  logic [3:0]         iMcuRegSelect,
  input  logic [7:0]         iMcuWriteData,
  input  logic               iIeWe,
  input  logic               iInterruptAck,
  output logic [7:0]         oIf,
  output logic [7:0]         oIe,
  output logic               oIme,
  output logic               oInterruptRequest,
  output logic [7:0]         oInterruptVector,
  output logic               oHaltWake
);

  localparam int unsigned IDX_W = $clog2(NUM_IRQ);

  int_state_e state_q, state_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic ime_q, ime_d;
  logic ei_q, ei_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] vec_q, vec_d;

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [IDX_W-1:0] win_idx;
  logic win_valid;
  logic [7:0] win_vec;
  logic if_wr;
  logic in_ack;

  assign pend = if_q & ie_q[NUM_IRQ-1:0];
  assign in_ack = (state_q == INT_ACK);
  assign if_wr = iMcuWe && (iMcuRegSelect == IF_SELECT);
  assign clr_mask = in_ack ? (NUM_IRQ'(1) << idx_q) : '0;

  interrupt_priority_encoder #(
    .NUM_IRQ(NUM_IRQ),
    .VECTOR_BASE(VECTOR_BASE),
    .IDX_W(IDX_W)
  ) u_prio (
    .pend_i(pend),
    .idx_o(win_idx),
    .valid_o(win_valid),
    .vec_o(win_vec)
  );

  // Write, then ack clear, then hardware set: a raised line always wins.
  always_comb begin
    if_d = if_q;
    if (if_wr) if_d = iMcuWriteData[NUM_IRQ-1:0];
    if_d = (if_d & ~clr_mask) | iInterruptRequest;
  end

  assign ie_d = iIeWe ? iMcuWriteData : ie_q;

  always_comb begin
    ime_d = ime_q;
    ei_d = ei_q;
    if (iEof) begin
      unique case (1'b1)
        (iOpcode == Z80_DI): begin
          ime_d = 1'b0;
          ei_d = 1'b0;
        end
        (iOpcode == Z80_RETI): begin
          ime_d = 1'b1;
          ei_d = 1'b0;
        end
        (iOpcode == Z80_EI): begin
          ime_d = ime_q | ei_q;
          ei_d = 1'b1;
        end
        default: begin
          ime_d = ime_q | ei_q;
          ei_d = 1'b0;
        end
      endcase
    end
    if (iInterruptAck || in_ack) begin
      ime_d = 1'b0;
      ei_d = 1'b0;
    end
  end

  // Arbitration uses IME as it stood before this boundary's opcode.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    vec_d = vec_q;
    case (state_q)
      INT_IDLE: begin
        if (iEof && ime_q && win_valid) begin
          state_d = INT_REQ;
          idx_d = win_idx;
          vec_d = win_vec;
        end
      end
      INT_REQ: begin
        if (iInterruptAck) state_d = INT_ACK;
      end
      INT_ACK: state_d = INT_IDLE;
      default: state_d = INT_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= INT_IDLE;
      if_q <= '0;
      ie_q <= 8'h00;
      ime_q <= 1'b0;
      ei_q <= 1'b0;
      idx_q <= '0;
      vec_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if_q <= if_d;
      ie_q <= ie_d;
      ime_q <= ime_d;
      ei_q <= ei_d;
      idx_q <= idx_d;
      vec_q <= vec_d;
    end
  end

  assign oIf = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign oIe = ie_q;
  assign oIme = ime_q;
  assign oInterruptRequest = (state_q == INT_REQ);
  assign oInterruptVector = vec_q;
  assign oHaltWake = |pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and random checks of the interrupt controller
// against a cycle-level behavioural model.
module tb_interrupt_controller;

  logic iClock = 1'b0;
  logic iReset;
  logic [4:0] iInterruptRequest;
  logic [7:0] iOpcode;
  logic iEof;
  logic iMcuWe;
  logic [3:0] iMcuRegSelect;
  logic [7:0] iMcuWriteData;
  logic iIeWe;
  logic iInterruptAck;
  logic [7:0] oIf;
  logic [7:0] oIe;
  logic oIme;
  logic oInterruptRequest;
  logic [7:0] oInterruptVector;
  logic oHaltWake;

  int errors = 0;
  int checks = 0;

  int m_if, m_ie, m_vec, m_bit;
  bit m_ime, m_eip, m_req, m_clr;

  interrupt_controller dut (
    .iClock(iClock),
    .iReset(iReset),
    .iInterruptRequest(iInterruptRequest),
    .iOpcode(iOpcode),
    .iEof(iEof),
    .iMcuWe(iMcuWe),
    .iMcuRegSelect(iMcuRegSelect),
    .iMcuWriteData(iMcuWriteData),
    .iIeWe(iIeWe),
    .iInterruptAck(iInterruptAck),
    .oIf(oIf),
    .oIe(oIe),
    .oIme(oIme),
    .oInterruptRequest(oInterruptRequest),
    .oInterruptVector(oInterruptVector),
    .oHaltWake(oHaltWake)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    iReset = 1'b0;
    iInterruptRequest = '0;
    iOpcode = 8'h00;
    iEof = 1'b0;
    iMcuWe = 1'b0;
    iMcuRegSelect = 4'h0;
    iMcuWriteData = 8'h00;
    iIeWe = 1'b0;
    iInterruptAck = 1'b0;
  endtask

  // Next model state from current model state and driven inputs.
  task automatic model_step();
    int p, nif, nie, nvec, nbit;
    bit nime, neip, nreq, nclr;
    if (iReset) begin
      m_if = 0; m_ie = 0; m_ime = 0; m_eip = 0;
      m_req = 0; m_clr = 0; m_vec = 0; m_bit = 0;
      return;
    end
    p = m_if & m_ie & 31;
    nif = m_if;
    if (iMcuWe && iMcuRegSelect == 4'hF) nif = iMcuWriteData & 31;
    if (m_clr) nif = nif & ~(1 << m_bit);
    nif = nif | iInterruptRequest;
    nie = iIeWe ? int'(iMcuWriteData) : m_ie;
    nime = m_ime;
    neip = m_eip;
    if (iEof) begin
      if (iOpcode == 8'hF3) begin
        nime = 0; neip = 0;
      end else if (iOpcode == 8'hD9) begin
        nime = 1; neip = 0;
      end else begin
        if (m_eip) nime = 1;
        neip = (iOpcode == 8'hFB);
      end
    end
    if (iInterruptAck || m_clr) begin
      nime = 0; neip = 0;
    end
    nreq = m_req; nclr = 0; nvec = m_vec; nbit = m_bit;
    if (m_req) begin
      if (iInterruptAck) begin
        nreq = 0; nclr = 1;
      end
    end else if (!m_clr && iEof && m_ime && p != 0) begin
      for (int i = 4; i >= 0; i--) if (p[i]) nbit = i;
      nvec = 64 + 8 * nbit;
      nreq = 1;
    end
    m_if = nif; m_ie = nie; m_ime = nime; m_eip = neip;
    m_req = nreq; m_clr = nclr; m_vec = nvec; m_bit = nbit;
  endtask

  task automatic cyc();
    model_step();
    @(posedge iClock);
    #1;
    chk("if", oIf, 8'(8'hE0 | m_if));
    chk("ie", oIe, 8'(m_ie));
    chk("ime", {7'b0, oIme}, {7'b0, m_ime});
    chk("req", {7'b0, oInterruptRequest}, {7'b0, m_req});
    chk("vec", oInterruptVector, 8'(m_vec));
    chk("halt", {7'b0, oHaltWake},
        {7'b0, ((m_if & m_ie & 31) != 0)});
    clear_inputs();
  endtask

  task automatic eof_op(input logic [7:0] op);
    iEof = 1'b1;
    iOpcode = op;
    cyc();
  endtask

  task automatic write_ie(input logic [7:0] v);
    iIeWe = 1'b1;
    iMcuWriteData = v;
    cyc();
  endtask

  task automatic pulse(input logic [4:0] v);
    iInterruptRequest = v;
    cyc();
  endtask

  task automatic ack_and_drain();
    iInterruptAck = 1'b1;
    cyc();
    chk("ack_req_drop", {7'b0, oInterruptRequest}, 8'h00);
    chk("ack_ime", {7'b0, oIme}, 8'h00);
    cyc();
  endtask

  initial begin
    clear_inputs();
    iReset = 1'b1;
    cyc();
    chk("rst_if", oIf, 8'hE0);
    chk("rst_ie", oIe, 8'h00);
    chk("rst_ime", {7'b0, oIme}, 8'h00);
    chk("rst_req", {7'b0, oInterruptRequest}, 8'h00);
    chk("rst_vec", oInterruptVector, 8'h00);

    // Timer dispatch and ack clear latency.
    write_ie(8'h04);
    eof_op(8'hD9);
    pulse(5'b00100);
    chk("t1_halt", {7'b0, oHaltWake}, 8'h01);
    eof_op(8'h00);
    chk("t1_req", {7'b0, oInterruptRequest}, 8'h01);
    chk("t1_vec", oInterruptVector, 8'h50);
    cyc();
    iInterruptAck = 1'b1;
    cyc();
    chk("t1_if_ack1", oIf, 8'hE4);
    chk("t1_ime_ack", {7'b0, oIme}, 8'h00);
    cyc();
    chk("t1_if_ack2", oIf, 8'hE0);

    // Simultaneous vblank+timer: vblank first, then timer.
    write_ie(8'h1F);
    eof_op(8'hD9);
    pulse(5'b00101);
    eof_op(8'h00);
    chk("t2_vec0", oInterruptVector, 8'h40);
    ack_and_drain();
    chk("t2_if_left", oIf, 8'hE4);
    eof_op(8'hD9);
    chk("t2_no_req", {7'b0, oInterruptRequest}, 8'h00);
    eof_op(8'h00);
    chk("t2_vec2", oInterruptVector, 8'h50);
    ack_and_drain();

    // EI delay: instruction after EI is not interrupted.
    write_ie(8'h04);
    pulse(5'b00100);
    eof_op(8'hFB);
    chk("t3_ei_req", {7'b0, oInterruptRequest}, 8'h00);
    eof_op(8'h00);
    chk("t3_next_req", {7'b0, oInterruptRequest}, 8'h00);
    chk("t3_ime", {7'b0, oIme}, 8'h01);
    eof_op(8'h00);
    chk("t3_req", {7'b0, oInterruptRequest}, 8'h01);
    chk("t3_vec", oInterruptVector, 8'h50);
    ack_and_drain();

    // IME off: halt wake only.
    write_ie(8'h10);
    pulse(5'b10000);
    chk("t4_halt", {7'b0, oHaltWake}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      eof_op(8'h00);
      chk("t4_no_req", {7'b0, oInterruptRequest}, 8'h00);
    end

    // Hardware set beats same-cycle CPU write.
    iMcuWe = 1'b1;
    iMcuRegSelect = 4'hF;
    iMcuWriteData = 8'h00;
    iInterruptRequest = 5'b00010;
    cyc();
    chk("t5_if", oIf, 8'hE2);

    // Reset while requesting.
    write_ie(8'h02);
    eof_op(8'hD9);
    eof_op(8'h00);
    chk("t6_req", {7'b0, oInterruptRequest}, 8'h01);
    chk("t6_vec", oInterruptVector, 8'h48);
    iReset = 1'b1;
    cyc();
    chk("t6_rst_req", {7'b0, oInterruptRequest}, 8'h00);
    chk("t6_rst_if", oIf, 8'hE0);
    chk("t6_rst_ie", oIe, 8'h00);
    chk("t6_rst_ime", {7'b0, oIme}, 8'h00);

    // Latched vector survives CPU clear and higher-priority arrival.
    write_ie(8'h1F);
    eof_op(8'hD9);
    pulse(5'b01000);
    eof_op(8'h00);
    chk("t7_vec", oInterruptVector, 8'h58);
    iMcuWe = 1'b1;
    iMcuRegSelect = 4'hF;
    iMcuWriteData = 8'h00;
    iInterruptRequest = 5'b00001;
    cyc();
    chk("t7_hold_req", {7'b0, oInterruptRequest}, 8'h01);
    chk("t7_hold_vec", oInterruptVector, 8'h58);
    ack_and_drain();
    chk("t7_if", oIf, 8'hE1);

    for (int n = 0; n < 3000; n++) begin
      iReset = ($urandom_range(0, 199) == 0);
      iInterruptRequest =
        ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
      iEof = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: iOpcode = 8'hF3;
        1: iOpcode = 8'hFB;
        2: iOpcode = 8'hD9;
        default: iOpcode = 8'($urandom);
      endcase
      iMcuWe = ($urandom_range(0, 15) == 0);
      iMcuRegSelect = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      iMcuWriteData = 8'($urandom);
      iIeWe = ($urandom_range(0, 15) == 0);
      iInterruptAck = m_req ? ($urandom_range(0, 2) == 0)
                            : ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
